// File: rtl/lfsr_stream_checker_pkg.sv
// Shared definitions for the Fibonacci LFSR generator and its stream checker.
// Both ends take WIDTH/TAPS defaults from here so their polynomials cannot drift apart.
package lfsr_stream_checker_pkg;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

  localparam int LFSR_WIDTH = 5;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 5'b11101;

  // Feedback bit of a Fibonacci LFSR; callers zero-extend to 32 bits.
  function automatic logic lfsr_next_bit(input logic [31:0] sreg, input logic [31:0] taps);
    return ^(sreg & taps);
  endfunction

endpackage

// File: rtl/lfsr_predict_core.sv
// LFSR shift register with parallel XOR predictor. Shifts in either an external
// bit (seeding / generator load) or its own predicted bit (free-running).
module lfsr_predict_core
  import lfsr_stream_checker_pkg::*;
#(
  parameter int                WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             sel_pred_i,
  input  logic             bit_i,
  output logic             pred_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  assign pred_o = lfsr_next_bit(32'(sreg_q), 32'(TAPS));
  // next_o is the value the register takes if en_i is high this cycle.
  assign next_o = {sreg_q[WIDTH-2:0], (sel_pred_i ? pred_o : bit_i)};

  always_comb begin
    sreg_d = sreg_q;
    if (clear_i) begin
      sreg_d = '0;
    end else if (en_i) begin
      sreg_d = next_o;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR stream checker: self-seeds from the first WIDTH bits, then
// predicts each bit, counts mismatches and re-seeds after LOSS_THRESH errors in a row.
module lfsr_stream_checker
  import lfsr_stream_checker_pkg::*;
#(
  parameter int               WIDTH       = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS,
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  // Stream input: in_bit_i is consumed on every cycle in_valid_i is high;
  // there is no back-pressure, the checker always accepts.
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic             clear_cnt_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             lost_pulse_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             dbg_state_o
);

  localparam int SEED_W   = $clog2(WIDTH + 1);
  localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

  chk_state_e          state_q, state_d;
  logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                err_pulse_q, err_pulse_d;
  logic                lost_pulse_q, lost_pulse_d;
  logic                locked_q, locked_d;

  logic             core_clear;
  logic             pred;
  logic             mis;
  logic [WIDTH-1:0] sreg_next;

  lfsr_predict_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (core_clear),
    .en_i       (in_valid_i),
    .sel_pred_i (state_q == CHECK),
    .bit_i      (in_bit_i),
    .pred_o     (pred),
    .next_o     (sreg_next)
  );

  assign mis = in_bit_i ^ pred;

  always_comb begin
    state_d      = state_q;
    seed_cnt_d   = seed_cnt_q;
    consec_d     = consec_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    lost_pulse_d = 1'b0;
    locked_d     = locked_q;
    core_clear   = 1'b0;
    if (in_valid_i) begin
      case (state_q)
        SEED: begin
          if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
            seed_cnt_d = '0;
            // An all-zero register is the LFSR lock-up state; keep seeding.
            if (sreg_next != '0) begin
              state_d  = CHECK;
              locked_d = 1'b1;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SEED_W'(1);
          end
        end
        CHECK: begin
          if (mis) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (consec_q == CONSEC_W'(LOSS_THRESH - 1)) begin
              state_d      = SEED;
              locked_d     = 1'b0;
              lost_pulse_d = 1'b1;
              seed_cnt_d   = '0;
              consec_d     = '0;
              core_clear   = 1'b1;
            end else begin
              consec_d = consec_q + CONSEC_W'(1);
            end
          end else begin
            consec_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clear_cnt_i) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SEED;
      seed_cnt_q   <= '0;
      consec_q     <= '0;
      err_count_q  <= '0;
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_cnt_q   <= seed_cnt_d;
      consec_q     <= consec_d;
      err_count_q  <= err_count_d;
      err_pulse_q  <= err_pulse_d;
      lost_pulse_q <= lost_pulse_d;
      locked_q     <= locked_d;
    end
  end

  assign locked_o     = locked_q;
  assign err_pulse_o  = err_pulse_q;
  assign lost_pulse_o = lost_pulse_q;
  assign err_count_o  = err_count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: a generator drives the stream with random gaps and
// planted bit flips; a queue-based model of the received history predicts every output.
module tb_lfsr_stream_checker;

  localparam int         W      = 5;
  localparam logic [4:0] TAPS_M = 5'b11101;
  localparam int         THRESH = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clear_cnt;
  logic        locked, err_pulse, lost_pulse, dbg_state;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lost_pulse4, dbg_state4;
  logic [3:0]  err_count4;

  lfsr_stream_checker #(.WIDTH(W), .TAPS(TAPS_M), .LOSS_THRESH(THRESH), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .clear_cnt_i(clear_cnt), .locked_o(locked), .err_pulse_o(err_pulse),
    .lost_pulse_o(lost_pulse), .err_count_o(err_count), .dbg_state_o(dbg_state)
  );

  lfsr_stream_checker #(.WIDTH(W), .TAPS(TAPS_M), .LOSS_THRESH(THRESH), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .clear_cnt_i(clear_cnt), .locked_o(locked4), .err_pulse_o(err_pulse4),
    .lost_pulse_o(lost_pulse4), .err_count_o(err_count4), .dbg_state_o(dbg_state4)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last W stream bits as the checker should hold them (newest at back).
  bit   exp_q[$];
  int   m_seed, m_consec, m_cnt16, m_cnt4;
  bit   m_locked;
  int   n_err_seen, n_lost_seen;
  logic [4:0] gen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(1'b0);
    m_seed = 0; m_consec = 0; m_cnt16 = 0; m_cnt4 = 0; m_locked = 1'b0;
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (TAPS_M[i]) p ^= exp_q[exp_q.size() - 1 - i];
    return p;
  endfunction

  // Driver: present one cycle of inputs, then advance the model and compare outputs.
  task automatic step(input bit v, input bit b, input bit clr);
    bit exp_err, exp_lost, p, any;
    in_valid = v; in_bit = b; clear_cnt = clr;
    @(posedge clock);
    #1;
    exp_err = 1'b0; exp_lost = 1'b0;
    if (v) begin
      if (!m_locked) begin
        exp_q.push_back(b);
        void'(exp_q.pop_front());
        m_seed++;
        if (m_seed == W) begin
          m_seed = 0;
          any = 1'b0;
          foreach (exp_q[i]) any |= exp_q[i];
          if (any) m_locked = 1'b1;
        end
      end else begin
        p = model_pred();
        exp_q.push_back(p);
        void'(exp_q.pop_front());
        if (b != p) begin
          exp_err = 1'b1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
          m_consec++;
          if (m_consec == THRESH) begin
            exp_lost = 1'b1;
            m_locked = 1'b0; m_seed = 0; m_consec = 0;
            foreach (exp_q[i]) exp_q[i] = 1'b0;
          end
        end else begin
          m_consec = 0;
        end
      end
    end
    if (clr) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end
    if (err_pulse === 1'b1) n_err_seen++;
    if (lost_pulse === 1'b1) n_lost_seen++;
    check_eq("err_pulse", 32'(err_pulse), 32'(exp_err));
    check_eq("lost_pulse", 32'(lost_pulse), 32'(exp_lost));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("err_count", 32'(err_count), 32'(m_cnt16));
    check_eq("err_count_w4", 32'(err_count4), 32'(m_cnt4));
  endtask

  // Send n generator bits with random idle gaps; flip bits in [flip_lo,flip_hi]
  // and every flip_per-th bit; assert clear_cnt together with bit clr_at.
  task automatic send(input int n, input int flip_lo, input int flip_hi,
                      input int flip_per, input int clr_at);
    bit fb, b;
    for (int idx = 0; idx < n; idx++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      fb  = ^(gen & TAPS_M);
      gen = {gen[3:0], fb};
      b   = fb;
      if ((idx >= flip_lo && idx <= flip_hi) || (flip_per > 0 && idx > 0 && idx % flip_per == 0))
        b = ~b;
      step(1'b1, b, idx == clr_at);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check_eq({tag, "_lost_pulse"}, 32'(lost_pulse), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    bit fb, b;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
    n_err_seen = 0; n_lost_seen = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    reset = 1'b0;

    // Clean stream from seed 0x0F
    gen = 5'h0F;
    send(100, -1, -1, 0, -1);
    check_eq("clean_err_pulses", 32'(n_err_seen), 32'd0);
    check_eq("clean_locked", 32'(locked), 32'd1);

    // Isolated errors at 20, 40, 60
    n_err_seen = 0;
    send(70, -1, -1, 20, -1);
    check_eq("iso_err_pulses", 32'(n_err_seen), 32'd3);
    check_eq("iso_err_count", 32'(err_count), 32'd3);
    check_eq("iso_locked", 32'(locked), 32'd1);

    // Loss of lock on 4 consecutive errors, then relock
    step(1'b0, 1'b0, 1'b1);
    n_lost_seen = 0;
    send(50, 30, 33, 0, -1);
    check_eq("loss_err_count", 32'(err_count), 32'd4);
    check_eq("loss_lost_pulses", 32'(n_lost_seen), 32'd1);
    check_eq("loss_relocked", 32'(locked), 32'd1);

    // Async reset between edges while locked
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    #1 reset = 1'b0;

    // All-zero seed is rejected, then lock from the real stream
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("zero_seed_unlocked", 32'(locked), 32'd0);
    send(30, -1, -1, 0, -1);
    check_eq("zero_seed_relocked", 32'(locked), 32'd1);

    // Saturation of the 4-bit counter with 20 isolated errors
    step(1'b0, 1'b0, 1'b1);
    send(201, -1, -1, 10, -1);
    check_eq("sat_count_w4", 32'(err_count4), 32'd15);
    check_eq("sat_count_w16", 32'(err_count), 32'd20);

    // clear_cnt coincident with a mismatch
    n_err_seen = 0;
    send(16, 15, 15, 0, 15);
    check_eq("clr_err_pulse", 32'(n_err_seen), 32'd1);
    check_eq("clr_err_count", 32'(err_count), 32'd0);

    // Random flips, gaps and clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      fb  = ^(gen & TAPS_M);
      gen = {gen[3:0], fb};
      b   = fb ^ ($urandom_range(0, 5) == 0);
      step(1'b1, b, 1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
